bus_master_port: RTL and testbench

BUS_MASTER_PORT -- requirements
Module: bus_master_port

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_timeout_cnt.sv | 40 ++++
 rtl/bus_master_port.sv | 153 +++++++++++++++
 tb/tb_bus_master_port.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the shared-bus master port:
//   - bus_state_e : transfer FSM states
//   - ERR_*       : completion status codes reported on rsp_error
//   - CNT_W       : width of the ADDR-phase wait counter (TIMEOUT <= 255)
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    DATA,
    DONE
  } bus_state_e;

  // 2'b11 is reserved and never produced.
  localparam logic [1:0] ERR_OK         = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b01;
  localparam logic [1:0] ERR_GRANT_LOST = 2'b10;

  localparam int CNT_W = 8;

endpackage

// File: rtl/bus_timeout_cnt.sv
// -----------------------------------------------------------------------------
// bus_timeout_cnt
// Wait counter for the address phase. Counts enabled cycles since the last
// clear and flags the enabled cycle that is the limit-th one, so the FSM can
// leave on that cycle's closing edge.
//
// Ports:
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   clear   in   return count to 0 (dominates enable)
//   enable  in   count this cycle
//   limit   in   CNT_W  number of enabled cycles allowed (1..255)
//   expired out  high during the limit-th enabled cycle
// -----------------------------------------------------------------------------
module bus_timeout_cnt
  import bus_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the number of cycles already spent, so the current cycle is
  // the last allowed one when count == limit - 1.
  assign expired = enable && (count == limit - CNT_W'(1));

endmodule

// File: rtl/bus_master_port.sv
// -----------------------------------------------------------------------------
// bus_master_port
// Converts a local valid/ready command into one transfer on a shared,
// arbitrated bus: request the bus (barq/bagd), present the address until the
// target is ready (with timeout), perform a single data strobe, then return
// a one-cycle completion with status and read data.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cmd_valid/cmd_ready            local command handshake
//   cmd_write, cmd_addr, cmd_wdata command contents, latched on accept
//   rsp_valid                      one-cycle completion pulse
//   rsp_rdata, rsp_error           read data / status, held until next completion
//   barq / bagd                    bus request to / grant from the arbiter
//   bus_addr, bus_wdata, bus_write bus command, zero outside ADDR/DATA
//   bus_rdata                      read data from target
//   address_valid, target_ready,   shared-bus handshake
//   data_strobe
//
// All outputs are registered; bagd/target_ready only steer the next state.
// -----------------------------------------------------------------------------
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_error,
  output logic              barq,
  input  logic              bagd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_write,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              address_valid,
  input  logic              target_ready,
  output logic              data_strobe
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  bus_state_e        state;
  bus_state_e        state_nxt;
  logic [1:0]        err_nxt;
  logic              cnt_expired;
  logic              drive_bus;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  // Counter is held at zero outside ADDR, so it always starts from 0 on entry.
  bus_timeout_cnt u_timeout_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ADDR),
    .enable  (state == ADDR),
    .limit   (LIMIT),
    .expired (cnt_expired)
  );

  // NOTE: combinational next-state logic uses blocking '=' and assigns every
  // output a default first, so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    err_nxt   = ERR_OK;
    case (state)
      IDLE: if (cmd_valid) state_nxt = REQ;
      REQ:  if (bagd)      state_nxt = ADDR;
      ADDR: begin
        // Grant loss beats target_ready, which beats timeout.
        if (!bagd) begin
          state_nxt = DONE;
          err_nxt   = ERR_GRANT_LOST;
        end else if (target_ready) begin
          state_nxt = DATA;
        end else if (cnt_expired) begin
          state_nxt = DONE;
          err_nxt   = ERR_TIMEOUT;
        end
      end
      DATA: begin
        state_nxt = DONE;
        err_nxt   = bagd ? ERR_OK : ERR_GRANT_LOST;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign drive_bus = (state_nxt == ADDR) || (state_nxt == DATA);

  // NOTE: all state in the clocked block uses non-blocking '<=' so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      barq          <= 1'b0;
      address_valid <= 1'b0;
      data_strobe   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_error     <= ERR_OK;
      bus_addr      <= '0;
      bus_wdata     <= '0;
      bus_write     <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      state <= state_nxt;

      // Control outputs are registered copies of the next-state decode.
      cmd_ready     <= (state_nxt == IDLE);
      barq          <= (state_nxt == REQ) || (state_nxt == ADDR) || (state_nxt == DATA);
      address_valid <= (state_nxt == ADDR);
      data_strobe   <= (state_nxt == DATA);
      rsp_valid     <= (state_nxt == DONE);

      if (state == IDLE && cmd_valid) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end

      bus_addr  <= drive_bus ? addr_q  : '0;
      bus_wdata <= drive_bus ? wdata_q : '0;
      bus_write <= drive_bus ? wr_q    : 1'b0;

      // DONE is only ever entered from ADDR or DATA, one cycle at a time.
      if (state_nxt == DONE) begin
        rsp_error <= err_nxt;
      end

      // Only a successful read updates rsp_rdata.
      if (state == DATA && bagd && !wr_q) begin
        rsp_rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// -----------------------------------------------------------------------------
// tb_bus_master_port
// Directed, table-driven bench for bus_master_port (ADDR_W=DATA_W=16,
// TIMEOUT=15). Inputs change 1 time unit after a rising edge; outputs are
// sampled at the same point, i.e. they show the state entered on that edge.
// -----------------------------------------------------------------------------
module tb_bus_master_port;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [1:0]  rsp_error;
  logic        barq;
  logic        bagd;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_write;
  logic [15:0] bus_rdata;
  logic        address_valid;
  logic        target_ready;
  logic        data_strobe;

  int errors = 0;
  int checks = 0;

  bus_master_port #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .barq          (barq),
    .bagd          (bagd),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_write     (bus_write),
    .bus_rdata     (bus_rdata),
    .address_valid (address_valid),
    .target_ready  (target_ready),
    .data_strobe   (data_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus expected outputs after the following edge.
  // e_ctl = {cmd_ready, barq, address_valid, data_strobe,
  //          rsp_valid, rsp_error[1:0], bus_write}
  typedef struct {
    logic        rst;
    logic        cv;
    logic        cw;
    logic [15:0] addr;
    logic [15:0] wd;
    logic        bg;
    logic        tr;
    logic [15:0] rd;
    logic [7:0]  e_ctl;
    logic [15:0] e_rdata;
    logic [15:0] e_baddr;
    logic [15:0] e_bwd;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until rsp_valid, counting ADDR and DATA cycles seen on the way.
  task automatic wait_done(input int budget, output int av_n, output int ds_n,
                           output logic [15:0] ds_wd, output logic ok);
    av_n  = 0;
    ds_n  = 0;
    ds_wd = '0;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (address_valid) av_n++;
      if (data_strobe) begin
        ds_n++;
        ds_wd = bus_wdata;
      end
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          av_n;
    int          ds_n;
    int          req_n;
    logic [15:0] ds_wd;
    logic        ok;

    //            rst   cv    cw    addr      wd        bg    tr    rd        e_ctl         e_rdata   e_baddr   e_bwd
    // Reset
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'b1000_0000, 16'h0000, 16'h0000, 16'h0000};
    // Read 0x0012, grant and ready already high, data 0xBEEF
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 8'b0100_0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 8'b0110_0000, 16'h0000, 16'h0012, 16'h0000};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 8'b0101_0000, 16'h0000, 16'h0012, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 8'b0000_1000, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 8'b1000_0000, 16'hBEEF, 16'h0000, 16'h0000};
    // Read 0x00A0, grant dropped during second ADDR cycle
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0000, 1'b1, 1'b0, 16'h1111, 8'b0100_0000, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 8'b0110_0000, 16'hBEEF, 16'h00A0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 8'b0110_0000, 16'hBEEF, 16'h00A0, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1111, 8'b0000_1100, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1111, 8'b1000_0100, 16'hBEEF, 16'h0000, 16'h0000};
    // Write 0x0055/0x1234, reset pulsed in ADDR
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h0055, 16'h1234, 1'b1, 1'b0, 16'h1111, 8'b0100_0100, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 8'b0110_0101, 16'hBEEF, 16'h0055, 16'h1234};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1111, 8'b1000_0000, 16'h0000, 16'h0000, 16'h0000};
    // Write 0x0056/0x4321 after reset completes normally; rsp_rdata untouched
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0056, 16'h4321, 1'b1, 1'b1, 16'h2222, 8'b0100_0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 8'b0110_0001, 16'h0000, 16'h0056, 16'h4321};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 8'b0101_0001, 16'h0000, 16'h0056, 16'h4321};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 8'b0000_1000, 16'h0000, 16'h0000, 16'h0000};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h2222, 8'b1000_0000, 16'h0000, 16'h0000, 16'h0000};

    for (int i = 0; i < NVEC; i++) begin
      reset        = vecs[i].rst;
      cmd_valid    = vecs[i].cv;
      cmd_write    = vecs[i].cw;
      cmd_addr     = vecs[i].addr;
      cmd_wdata    = vecs[i].wd;
      bagd         = vecs[i].bg;
      target_ready = vecs[i].tr;
      bus_rdata    = vecs[i].rd;
      step();
      check($sformatf("vec%0d", i),
            64'({cmd_ready, barq, address_valid, data_strobe, rsp_valid, rsp_error, bus_write,
                 rsp_rdata, bus_addr, bus_wdata}),
            64'({vecs[i].e_ctl, vecs[i].e_rdata, vecs[i].e_baddr, vecs[i].e_bwd}));
    end

    // Write 0x0034/0x5A5A with the grant arriving after 6 REQ cycles.
    bagd         = 1'b0;
    target_ready = 1'b1;
    bus_rdata    = 16'h3333;
    issue(1'b1, 16'h0034, 16'h5A5A);
    req_n = (barq && !address_valid) ? 1 : 0;
    for (int g = 0; g < 40 && !address_valid; g++) begin
      bagd = (req_n >= 6);
      step();
      if (barq && !address_valid) req_n++;
    end
    check("grant_delay_req_cycles", 64'(req_n), 64'd6);
    check("grant_delay_addr_phase", 64'({address_valid, bus_write, bus_addr}), 64'({1'b1, 1'b1, 16'h0034}));
    wait_done(10, av_n, ds_n, ds_wd, ok);
    check("grant_delay_done_seen", 64'(ok), 64'd1);
    check("grant_delay_strobes", 64'(ds_n), 64'd1);
    check("grant_delay_wdata", 64'(ds_wd), 64'h5A5A);
    check("grant_delay_status", 64'({rsp_error, rsp_rdata}), 64'({2'b00, 16'h0000}));
    step();
    check("grant_delay_idle", 64'({cmd_ready, barq, rsp_valid}), 64'b100);

    // Target never ready: 15 ADDR cycles then timeout.
    bagd         = 1'b1;
    target_ready = 1'b0;
    bus_rdata    = 16'h4444;
    issue(1'b0, 16'h0077, 16'h0000);
    wait_done(40, av_n, ds_n, ds_wd, ok);
    check("timeout_done_seen", 64'(ok), 64'd1);
    check("timeout_addr_cycles", 64'(av_n), 64'd15);
    check("timeout_strobes", 64'(ds_n), 64'd0);
    check("timeout_status", 64'({barq, rsp_error, rsp_rdata}), 64'({1'b0, 2'b01, 16'h0000}));
    step();
    check("timeout_rsp_pulse", 64'({rsp_valid, cmd_ready, rsp_error}), 64'({1'b0, 1'b1, 2'b01}));

    // target_ready arrives on the 15th ADDR cycle, same cycle as the timeout.
    bus_rdata = 16'hCAFE;
    issue(1'b0, 16'h0088, 16'h0000);
    av_n = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (address_valid) av_n++;
    end
    check("race_addr_cycles", 64'(av_n), 64'd15);
    target_ready = 1'b1;
    step();
    check("race_data_taken", 64'({data_strobe, address_valid, bus_addr}), 64'({1'b1, 1'b0, 16'h0088}));
    target_ready = 1'b0;
    step();
    check("race_status", 64'({rsp_valid, rsp_error, rsp_rdata}), 64'({1'b1, 2'b00, 16'hCAFE}));
    step();

    // Grant lost during DATA: error 10, read data not captured.
    target_ready = 1'b1;
    bus_rdata    = 16'h9999;
    issue(1'b0, 16'h0099, 16'h0000);
    step();
    step();
    check("data_loss_strobe", 64'(data_strobe), 64'd1);
    bagd = 1'b0;
    step();
    check("data_loss_status", 64'({rsp_valid, barq, rsp_error, rsp_rdata}),
          64'({1'b1, 1'b0, 2'b10, 16'hCAFE}));
    bagd = 1'b1;
    step();
    check("data_loss_idle", 64'({cmd_ready, rsp_valid}), 64'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
